// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_pkg                                                |
// | Brief   : Shared constants and helpers for the configurable UART |
// |           receiver (state encodings, parity modes, divisor floor)|
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package uart_pkg;

  // 3-bit receiver state encodings
  localparam logic [2:0] c_ST_IDLE       = 3'd0;
  localparam logic [2:0] c_ST_START      = 3'd1;
  localparam logic [2:0] c_ST_DATA       = 3'd2;
  localparam logic [2:0] c_ST_PARITY     = 3'd3;
  localparam logic [2:0] c_ST_STOP       = 3'd4;
  localparam logic [2:0] c_ST_BREAK_WAIT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE       = c_ST_IDLE,
    ST_START      = c_ST_START,
    ST_DATA       = c_ST_DATA,
    ST_PARITY     = c_ST_PARITY,
    ST_STOP       = c_ST_STOP,
    ST_BREAK_WAIT = c_ST_BREAK_WAIT
  } rx_state_t;

  // Parity mode, captured once per frame
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Smallest usable bit period; smaller divisors are raised to this
  localparam int MIN_CLKS_PER_BIT = 4;

  // Parity check: even mode flags XOR(data) != bit, odd mode flags XOR(data) == bit
  function automatic logic parity_error(input logic [1:0] mode,
                                        input logic       data_xor,
                                        input logic       par_bit);
    logic v_err;
    v_err = 1'b0;
    case (mode)
      PAR_EVEN: v_err = data_xor ^ par_bit;
      PAR_ODD:  v_err = ~(data_xor ^ par_bit);
      default:  v_err = 1'b0;
    endcase
    return v_err;
  endfunction

  // 2-of-3 majority
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx_sampler                                         |
// | Brief   : Two-flop synchroniser for the serial line plus the bit  |
// |           decision value. With UART_RX_MAJORITY_EN defined the    |
// |           bit is a 2-of-3 vote over the last three synced samples;|
// |           otherwise it is the synced line itself.                 |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Rx_Serial,
  output logic o_Rx_Sync,
  output logic o_Rx_Bit
);

  logic r_sync1;
  logic r_sync2;

  // Metastability guard; both stages idle high so reset never looks like a start bit
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_Rx_Serial;
      r_sync2 <= r_sync1;
    end
  end

  assign o_Rx_Sync = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  // Keep the two previous synced samples so the vote spans S-1, S, S+1
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
    end
  end

  assign o_Rx_Bit = majority3(r_sync2, r_hist[0], r_hist[1]);
`else
  assign o_Rx_Bit = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx_cfg                                             |
// | Brief   : Runtime-configurable UART receiver: DATA_BITS data,     |
// |           optional even/odd parity, STOP_BITS stop bits, runtime  |
// |           baud divisor, parity/framing error and break detection. |
// |           Define UART_RX_MAJORITY_EN for 3-sample majority voting |
// |           (DV then arrives one cycle later).                      |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  input  logic [CNT_W-1:0]     i_Clks_Per_Bit,
  input  logic                 i_Parity_En,
  input  logic                 i_Parity_Odd,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Error,
  output logic                 o_Frame_Error,
  output logic                 o_Break
);

  localparam int               c_IDX_W   = 4;
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_MIN_DIV = CNT_W'(MIN_CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  // The vote needs the S+1 sample, so every decision moves one clock later
  localparam logic [CNT_W-1:0] c_VOTE_DLY = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] c_VOTE_DLY = CNT_W'(0);
`endif

  logic w_sync;
  logic w_bit;

  uart_rx_sampler u_sampler (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx_Sync   (w_sync),
    .o_Rx_Bit    (w_bit)
  );

  rx_state_t            r_state,     w_state_next;
  logic [CNT_W-1:0]     r_count,     w_count_next;
  logic [CNT_W-1:0]     r_div,       w_div_next;
  logic [1:0]           r_par_mode,  w_par_mode_next;
  logic [c_IDX_W-1:0]   r_bit_idx,   w_bit_idx_next;
  logic                 r_stop_idx,  w_stop_idx_next;
  logic [DATA_BITS-1:0] r_shift,     w_shift_next;
  logic                 r_zero,      w_zero_next;
  logic                 r_perr_acc,  w_perr_acc_next;
  logic                 r_ferr_acc,  w_ferr_acc_next;
  logic                 r_brk_acc,   w_brk_acc_next;
  logic                 r_dv,        w_dv_next;
  logic [DATA_BITS-1:0] r_byte,      w_byte_next;
  logic                 r_perr,      w_perr_next;
  logic                 r_ferr,      w_ferr_next;
  logic                 r_brk,       w_brk_next;

  logic [CNT_W-1:0] w_clamped_div;
  logic [CNT_W-1:0] w_start_pt;
  logic             w_bit_end;
  logic             w_last_bit;
  logic             w_last_stop;
  logic             w_stop_ferr;
  logic             w_stop_brk;
  logic [1:0]       w_cfg_par_mode;

  assign w_clamped_div  = (i_Clks_Per_Bit < c_MIN_DIV) ? c_MIN_DIV : i_Clks_Per_Bit;
  assign w_cfg_par_mode = !i_Parity_En ? PAR_NONE : (i_Parity_Odd ? PAR_ODD : PAR_EVEN);
  assign w_start_pt     = ((r_div - c_ONE) >> 1) + c_VOTE_DLY;
  assign w_bit_end      = (r_count == (r_div - c_ONE));
  assign w_last_bit     = (r_bit_idx == c_IDX_W'(DATA_BITS - 1));
  assign w_last_stop    = (r_stop_idx == 1'(STOP_BITS - 1));
  // A low stop bit is a framing error; a break is judged on the first stop bit only
  assign w_stop_ferr    = r_ferr_acc | ~w_bit;
  assign w_stop_brk     = (r_stop_idx == 1'b0) ? (r_zero & ~w_bit) : r_brk_acc;

  // Next-state and datapath decisions for the receive FSM
  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count + c_ONE;
    w_div_next      = r_div;
    w_par_mode_next = r_par_mode;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_shift_next    = r_shift;
    w_zero_next     = r_zero;
    w_perr_acc_next = r_perr_acc;
    w_ferr_acc_next = r_ferr_acc;
    w_brk_acc_next  = r_brk_acc;
    w_dv_next       = 1'b0;
    w_byte_next     = r_byte;
    w_perr_next     = r_perr;
    w_ferr_next     = r_ferr;
    w_brk_next      = r_brk;

    case (r_state)
      ST_IDLE: begin
        w_count_next = '0;
        if (!w_sync) begin
          w_state_next    = ST_START;
          w_div_next      = w_clamped_div;
          w_par_mode_next = w_cfg_par_mode;
        end
      end
      ST_START: begin
        if (r_count == w_start_pt) begin
          w_count_next = '0;
          if (!w_bit) begin
            w_state_next    = ST_DATA;
            w_bit_idx_next  = '0;
            w_stop_idx_next = 1'b0;
            w_zero_next     = 1'b1;
            w_perr_acc_next = 1'b0;
            w_ferr_acc_next = 1'b0;
            w_brk_acc_next  = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_count_next = '0;
          w_shift_next = {w_bit, r_shift[DATA_BITS-1:1]};
          if (w_bit) w_zero_next = 1'b0;
          if (w_last_bit) begin
            w_state_next = (r_par_mode != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_count_next    = '0;
          w_perr_acc_next = parity_error(r_par_mode, ^r_shift, w_bit);
          if (w_bit) w_zero_next = 1'b0;
          w_state_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_count_next    = '0;
          w_ferr_acc_next = w_stop_ferr;
          w_brk_acc_next  = w_stop_brk;
          if (w_last_stop) begin
            w_dv_next    = 1'b1;
            w_byte_next  = r_shift;
            w_perr_next  = r_perr_acc;
            w_ferr_next  = w_stop_ferr | w_stop_brk;
            w_brk_next   = w_stop_brk;
            w_state_next = w_stop_brk ? ST_BREAK_WAIT : ST_IDLE;
          end else begin
            w_stop_idx_next = r_stop_idx + 1'b1;
          end
        end
      end
      ST_BREAK_WAIT: begin
        w_count_next = '0;
        if (w_sync) w_state_next = ST_IDLE;
      end
      default: begin
        w_count_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and output registers; reset drops any partial frame
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_div      <= c_MIN_DIV;
      r_par_mode <= PAR_NONE;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_zero     <= 1'b0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_brk_acc  <= 1'b0;
      r_dv       <= 1'b0;
      r_byte     <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_div      <= w_div_next;
      r_par_mode <= w_par_mode_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_shift    <= w_shift_next;
      r_zero     <= w_zero_next;
      r_perr_acc <= w_perr_acc_next;
      r_ferr_acc <= w_ferr_acc_next;
      r_brk_acc  <= w_brk_acc_next;
      r_dv       <= w_dv_next;
      r_byte     <= w_byte_next;
      r_perr     <= w_perr_next;
      r_ferr     <= w_ferr_next;
      r_brk      <= w_brk_next;
    end
  end

  assign o_Rx_DV        = r_dv;
  assign o_Rx_Byte      = r_byte;
  assign o_Parity_Error = r_perr;
  assign o_Frame_Error  = r_ferr;
  assign o_Break        = r_brk;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_uart_rx_cfg                                          |
// | Brief   : Scoreboard bench for uart_rx_cfg: an 8-bit/1-stop and a |
// |           7-bit/2-stop instance, directed plus random frames.     |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        line8, line7;
  logic [15:0] cpb;
  logic        par_en, par_odd;

  logic       dv8, perr8, ferr8, brk8;
  logic [7:0] byte8;
  logic       dv7, perr7, ferr7, brk7;
  logic [6:0] byte7;

  exp_t q8[$];
  exp_t q7[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_dv8 = 1'b0;
  logic prev_dv7 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_BITS(8), .CNT_W(16), .STOP_BITS(1)) dut8 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line8), .i_Clks_Per_Bit(cpb),
    .i_Parity_En(par_en), .i_Parity_Odd(par_odd), .o_Rx_DV(dv8), .o_Rx_Byte(byte8),
    .o_Parity_Error(perr8), .o_Frame_Error(ferr8), .o_Break(brk8)
  );

  uart_rx_cfg #(.DATA_BITS(7), .CNT_W(16), .STOP_BITS(2)) dut7 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line7), .i_Clks_Per_Bit(cpb),
    .i_Parity_En(par_en), .i_Parity_Odd(par_odd), .o_Rx_DV(dv7), .o_Rx_Byte(byte7),
    .o_Parity_Error(perr7), .o_Frame_Error(ferr7), .o_Break(brk7)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: expected result of one frame from its bit contents
  function automatic exp_t model(input logic [8:0] data, input int nbits, input bit pen,
                                 input bit podd, input bit pbit, input bit s0, input bit s1,
                                 input int nstop);
    exp_t e;
    logic [8:0] m;
    int ones;
    bit data_odd;
    m = data & 9'((1 << nbits) - 1);
    ones = $countones(m);
    data_odd = (ones % 2) == 1;
    e.data = m;
    e.perr = pen && (podd ? (data_odd == pbit) : (data_odd != pbit));
    e.brk  = (m == 0) && (!pen || !pbit) && !s0;
    e.ferr = !s0 || (nstop == 2 && !s1) || e.brk;
    return e;
  endfunction

  task automatic set_line(input int which, input logic v);
    if (which == 0) line8 = v;
    else            line7 = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame bit by bit; optionally change the divisor input part way through
  task automatic send(input int which, input int dprog, input logic [8:0] data, input int nbits,
                      input bit pen, input bit podd, input bit pbit, input bit s0, input bit s1,
                      input int nstop, input int chg_at, input int chg_val, input bit exp_dv);
    bit   bits[$];
    int   period;
    int   cyc;
    exp_t e;
    period = (dprog < 4) ? 4 : dprog;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(s0);
    if (nstop == 2) bits.push_back(s1);
    e = model(data, nbits, pen, podd, pbit, s0, s1, nstop);
    if (exp_dv) begin
      if (which == 0) q8.push_back(e);
      else            q7.push_back(e);
    end
    @(negedge clk);
    cpb     = 16'(dprog);
    par_en  = pen;
    par_odd = podd;
    cyc = 0;
    foreach (bits[k]) begin
      set_line(which, bits[k]);
      repeat (period) begin
        @(negedge clk);
        cyc++;
        if (cyc == chg_at) cpb = 16'(chg_val);
      end
    end
    set_line(which, 1'b1);
  endtask

  // Scoreboard monitor for the 8-bit receiver
  always @(negedge clk) begin
    if (dv8 === 1'b1) begin
      exp_t e;
      if (prev_dv8) begin
        n_checks++; n_fail++;
        $display("FAIL dut8_dv_width: got DV high 2 cycles, expected 1");
      end
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut8_unexpected_dv: got DV byte 0x%0h, expected no DV", byte8);
      end else begin
        e = q8.pop_front();
        check("dut8_byte", 32'(byte8), 32'(e.data));
        check("dut8_perr", 32'(perr8), 32'(e.perr));
        check("dut8_ferr", 32'(ferr8), 32'(e.ferr));
        check("dut8_brk",  32'(brk8),  32'(e.brk));
      end
    end
    prev_dv8 = dv8;
  end

  // Scoreboard monitor for the 7-bit / 2-stop receiver
  always @(negedge clk) begin
    if (dv7 === 1'b1) begin
      exp_t e;
      if (prev_dv7) begin
        n_checks++; n_fail++;
        $display("FAIL dut7_dv_width: got DV high 2 cycles, expected 1");
      end
      if (q7.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut7_unexpected_dv: got DV byte 0x%0h, expected no DV", byte7);
      end else begin
        e = q7.pop_front();
        check("dut7_byte", 32'(byte7), 32'(e.data));
        check("dut7_perr", 32'(perr7), 32'(e.perr));
        check("dut7_ferr", 32'(ferr7), 32'(e.ferr));
        check("dut7_brk",  32'(brk7),  32'(e.brk));
      end
    end
    prev_dv7 = dv7;
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dv8"},   32'(dv8),   32'd0);
    check({tag, "_byte8"}, 32'(byte8), 32'd0);
    check({tag, "_perr8"}, 32'(perr8), 32'd0);
    check({tag, "_ferr8"}, 32'(ferr8), 32'd0);
    check({tag, "_brk8"},  32'(brk8),  32'd0);
    check({tag, "_dv7"},   32'(dv7),   32'd0);
    check({tag, "_byte7"}, 32'(byte7), 32'd0);
    check({tag, "_perr7"}, 32'(perr7), 32'd0);
    check({tag, "_ferr7"}, 32'(ferr7), 32'd0);
    check({tag, "_brk7"},  32'(brk7),  32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    int         dp, gap;
    bit         pen, podd, pbit, s0;
    rst = 1'b1; line8 = 1'b1; line7 = 1'b1; cpb = 16'd16; par_en = 1'b0; par_odd = 1'b0;
    idle(3);
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(5);

    // 8N1 basic frame
    send(0, 16, 9'hA5, 8, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    idle(4);
    // 8E1 / 8O1 parity cases
    send(0, 16, 9'h03, 8, 1, 0, 1, 1, 1, 1, 0, 0, 1);
    idle(2);
    send(0, 16, 9'h03, 8, 1, 0, 0, 1, 1, 1, 0, 0, 1);
    idle(2);
    send(0, 16, 9'h03, 8, 1, 1, 1, 1, 1, 1, 0, 0, 1);
    idle(4);

    // 7-bit, 2 stops, second stop low
    send(1, 10, 9'h55, 7, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    idle(20);

    // Short low glitch on an idle line, then a good frame
    cpb = 16'd16; par_en = 1'b0;
    line8 = 1'b0; idle(3); line8 = 1'b1;
    idle(40);
    send(0, 16, 9'h3C, 8, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    idle(4);

    // Break: line low for 20 bit times
    q8.push_back(model(9'h00, 8, 0, 0, 0, 0, 0, 1));
    line8 = 1'b0; idle(20 * 16); line8 = 1'b1;
    idle(40);
    send(0, 16, 9'h81, 8, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    idle(4);

    // Reset in the middle of the data bits of 0xFF
    line8 = 1'b0; idle(16); line8 = 1'b1;
    idle(16 * 3 + 8);
    rst = 1'b1;
    idle(1);
    check_zero_outputs("midreset");
    rst = 1'b0;
    idle(16 * 8);
    // Divisor input changes mid-frame and must be ignored
    send(0, 16, 9'h12, 8, 0, 0, 0, 1, 1, 1, 40, 7, 1);
    idle(4);
    // Divisor below the floor behaves as 4
    send(0, 2, 9'h6B, 8, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    idle(4);

    // Random frames, 8-bit receiver, gaps down to zero (back-to-back)
    for (int i = 0; i < 24; i++) begin
      dp   = $urandom_range(0, 24);
      d    = 9'($urandom);
      if ($urandom_range(0, 7) == 0) d = '0;
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbit = 1'($urandom);
      gap  = $urandom_range(0, 3);
      send(0, dp, d, 8, pen, podd, pbit, 1, 1, 1, 0, 0, 1);
      idle(gap);
    end
    idle(8);

    // Random frames, 7-bit / 2-stop receiver, with first-stop errors and breaks
    for (int i = 0; i < 14; i++) begin
      dp   = $urandom_range(4, 20);
      d    = 9'($urandom);
      if ($urandom_range(0, 3) == 0) d = '0;
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbit = 1'($urandom);
      s0   = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 3);
      send(1, dp, d, 7, pen, podd, pbit, s0, 1, 2, 0, 0, 1);
      idle(gap);
    end

    for (int k = 0; k < 2000 && (q8.size() != 0 || q7.size() != 0); k++) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q7_drained", 32'(q7.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
